ysyx_24070003_ifu: RTL and testbench
====================================

Name: ysyx_24070003_ifu

Overview:
Instruction-fetch stage that owns the architectural fetch PC. Each cycle it drives the current PC to the BTB and takes the BTB's same-cycle prediction to choose the next fetch PC. It issues one instruction-memory request at a time over a valid/ready handshake and buffers returned instructions, with PC and prediction tags, in a small queue toward the decoder. EXU redirects flush the queue and discard any stale in-flight response.

Parameters:
RESET_PC, 32'h3000_0000, first fetch address after reset
QDEPTH, 2, instruction queue entries (power of two, >=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
btb_cur_pc  out  32  current fetch PC to BTB (equals pc register)
btb_pred_pc  in  32  BTB predicted target for btb_cur_pc
btb_pred_valid  in  1  BTB hit for btb_cur_pc
ifetch_req_valid  out  1  fetch request valid
ifetch_req_ready  in  1  memory accepts request
ifetch_req_addr  out  32  fetch address
ifetch_rsp_valid  in  1  fetch response valid (always accepted)
ifetch_rsp_data  in  32  instruction word
ifetch_rsp_err  in  1  access fault on this fetch
redirect_valid  in  1  EXU redirect (mispredict/trap/mret)
redirect_pc  in  32  redirect target
out_valid  out  1  queue head valid
out_ready  in  1  decoder consumes head
out_pc  out  32  PC of head instruction
out_inst  out  32  instruction word
out_pred_taken  out  1  BTB hit recorded at fetch
out_pred_pc  out  32  next PC chosen at fetch
out_err  out  1  fetch fault for head

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=IDLE, queue empty, drop=0; ifetch_req_valid=0, out_valid=0, out_* data=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE -> REQ when (count < QDEPTH) and no redirect this cycle.
- REQ: ifetch_req_valid=1, ifetch_req_addr=pc. Valid and address stay stable until ready; a request is never withdrawn. On accept: latch pc, btb_pred_valid and the chosen next PC into in-flight registers. Set pc <= btb_pred_valid ? btb_pred_pc : pc+4 (mod 2^32). Go to WAIT.
- WAIT: on ifetch_rsp_valid, if drop=0 push {inflight_pc, rsp_data, pred_taken, pred_pc, rsp_err}; if drop=1 discard and clear drop. Go to REQ if count_after_push < QDEPTH, else IDLE. Same-cycle REQ->accept is not allowed; at most one outstanding request.
- Room rule: a new request is only issued when the queue can take its response, so a push into a full queue cannot occur.
- Redirect (highest priority):
  - pc <= redirect_pc, queue flushed (count=0, out_valid=0 next cycle); a same-cycle pop is ignored.
  - In WAIT, or in REQ with the request accepted that cycle: drop <= 1.
  - In REQ not yet accepted: the held request continues with its original address, and drop is set when it is accepted. pc is overwritten by redirect_pc, not by the prediction.
- Simultaneous redirect and rsp_valid: the response is discarded.
- Queue: circular, head/tail pointers wrap modulo QDEPTH. Push and pop in the same cycle keep count. out_* drive the head entry combinationally from storage.
- btb_cur_pc = pc at all times. Prediction is sampled only on request acceptance.
- Fault entries flow like normal instructions. Handling faults is the decoder's job.

Decomposition:
- Shared header ysyx_24070003_defs.vh holds RESET_PC, FSM state encodings and the queue entry field widths/offsets. These are reused by the IDU and BTB update logic.
- One sub-module, ysyx_24070003_ifu_queue: a parameterised synchronous FIFO with flush, push, pop, count, and head outputs. The top level holds the FSM, PC, and in-flight/drop registers.

Test Plan:
- Reset then ready=1, 1-cycle response latency, BTB miss → request addresses 0x30000000, 0x30000004, 0x30000008; out_pc matches in order with out_pred_taken=0.
- BTB hit at 0x30000004 with pred_pc=0x30000100 → next request address 0x30000100; entry for 0x30000004 has out_pred_taken=1, out_pred_pc=0x30000100.
- out_ready=0 → after 2 responses, ifetch_req_valid stays 0 (IDLE, count=2). Raise out_ready → fetch resumes with no lost or duplicated PC.
- Redirect to 0x80000000 while in WAIT → the pending response is discarded, out_valid=0 next cycle, and the next request address is 0x80000000.
- Redirect while in REQ with ready=0 for 3 cycles → ifetch_req_addr holds its old value until accept, that response is dropped, then 0x80000000 is fetched.
- rsp_err=1 on 0x30000008 → an entry is pushed with out_err=1 and fetch continues at 0x3000000C. Asserting reset mid-WAIT → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ysyx_24070003_ifu_pkg.sv
// Shared IFU definitions: default reset PC, fetch FSM encoding, instruction-queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Decode and BTB-update logic reuse the entry layout to unpack queue heads.
package ysyx_24070003_ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h3000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // queue has no room for another response
    ST_REQ  = 2'd1,  // request held on the bus until accepted
    ST_WAIT = 2'd2   // one request outstanding, waiting for its response
  } ifu_state_e;

  // Queue entry, MSB first: pc[97:66] inst[65:34] pred_taken[33] pred_pc[32:1] err[0]
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        err;
  } ifq_entry_t;

  localparam int IFQ_ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/ysyx_24070003_ifu_queue.sv
// Circular FIFO with flush; head entry is driven combinationally from storage.
// Latency: a push is visible at the head one cycle later; pop takes effect at the clock edge.
// Backpressure: push into a full queue and pop from an empty one are ignored; flush wins over both.
// Ports: clock/reset, flush, push/push_data, pop, head_valid/head_data, count.
module ysyx_24070003_ifu_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_ptr;
  logic [AW-1:0]    tail_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push & (count != CW'(DEPTH));
  assign do_pop     = pop & (count != '0);
  assign head_valid = (count != '0);
  assign head_data  = mem[head_ptr];

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + AW'(1);
      end
      if (do_pop) begin
        head_ptr <= head_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_24070003_ifu.sv
// Fetch stage: owns the fetch PC, follows BTB predictions, one outstanding imem request, queue to decode.
// Latency: request one cycle after room appears; response visible at out_* the cycle after it returns.
// Backpressure: no request is issued unless the queue can hold its response; redirect flushes and drops stale data.
// Ports: btb_* (PC out, prediction in), ifetch_req_* / ifetch_rsp_* (imem), redirect_* (EXU), out_* (decoder).
module ysyx_24070003_ifu
  import ysyx_24070003_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] btb_cur_pc,
  input  logic [31:0] btb_pred_pc,
  input  logic        btb_pred_valid,
  output logic        ifetch_req_valid,
  input  logic        ifetch_req_ready,
  output logic [31:0] ifetch_req_addr,
  input  logic        ifetch_rsp_valid,
  input  logic [31:0] ifetch_rsp_data,
  input  logic        ifetch_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_pc,
  output logic        out_err
);

  localparam int CW = $clog2(QDEPTH) + 1;

  ifu_state_e    state;
  logic [31:0]   pc;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic [31:0]   inflight_pc;
  logic          inflight_taken;
  logic [31:0]   inflight_pred_pc;
  // Set while the held or outstanding request belongs to a path that a redirect abandoned.
  logic          drop;

  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   chosen_pc;
  logic [CW-1:0] q_count;
  logic [CW-1:0] count_after;
  logic          room_after;
  logic          q_valid;
  ifq_entry_t    push_ent;
  ifq_entry_t    head_ent;

  assign btb_cur_pc       = pc;
  assign ifetch_req_valid = req_valid;
  assign ifetch_req_addr  = req_addr;

  assign accept    = req_valid & ifetch_req_ready;
  assign chosen_pc = btb_pred_valid ? btb_pred_pc : pc + 32'd4;
  assign push      = (state == ST_WAIT) & ifetch_rsp_valid & ~drop & ~redirect_valid;
  assign pop       = q_valid & out_ready & ~redirect_valid;

  // Occupancy after this edge; decides whether WAIT may chain straight into another request.
  always_comb begin
    count_after = q_count;
    if (redirect_valid) begin
      count_after = '0;
    end else begin
      if (push) count_after = count_after + CW'(1);
      if (pop)  count_after = count_after - CW'(1);
    end
  end

  assign room_after = (count_after < CW'(QDEPTH));

  always_comb begin
    push_ent            = '0;
    push_ent.pc         = inflight_pc;
    push_ent.inst       = ifetch_rsp_data;
    push_ent.pred_taken = inflight_taken;
    push_ent.pred_pc    = inflight_pred_pc;
    push_ent.err        = ifetch_rsp_err;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      pc               <= RESET_PC;
      req_valid        <= 1'b0;
      req_addr         <= RESET_PC;
      inflight_pc      <= '0;
      inflight_taken   <= 1'b0;
      inflight_pred_pc <= '0;
      drop             <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (q_count < CW'(QDEPTH)) begin
            state     <= ST_REQ;
            req_valid <= 1'b1;
            req_addr  <= pc;
          end
        end

        ST_REQ: begin
          // The held request keeps its address; it is only marked stale.
          if (redirect_valid) begin
            pc   <= redirect_pc;
            drop <= 1'b1;
          end
          if (accept) begin
            inflight_pc      <= req_addr;
            inflight_taken   <= btb_pred_valid;
            inflight_pred_pc <= chosen_pc;
            // A stale request must not advance pc past the redirect target.
            if (!redirect_valid && !drop) begin
              pc <= chosen_pc;
            end
            req_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          if (ifetch_rsp_valid) begin
            drop <= 1'b0;
            if (room_after) begin
              state     <= ST_REQ;
              req_valid <= 1'b1;
              req_addr  <= redirect_valid ? redirect_pc : pc;
            end else begin
              state <= ST_IDLE;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  ysyx_24070003_ifu_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (IFQ_ENTRY_W)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_ent),
    .pop        (pop),
    .head_valid (q_valid),
    .head_data  (head_ent),
    .count      (q_count)
  );

  assign out_valid      = q_valid;
  assign out_pc         = head_ent.pc;
  assign out_inst       = head_ent.inst;
  assign out_pred_taken = head_ent.pred_taken;
  assign out_pred_pc    = head_ent.pred_pc;
  assign out_err        = head_ent.err;

endmodule

// File: tb/tb_ysyx_24070003_ifu.sv
// Bench for the fetch stage: transaction-level reference (expected fetch stream, decode queue, memory).
// Directed scenarios pin the reference with literal values; a random phase stresses handshakes and redirects.
// Every cycle the decode-side outputs are compared with the reference queue head.
module tb_ysyx_24070003_ifu;

  localparam logic [31:0] RST_PC = 32'h3000_0000;
  localparam int          QD     = 2;

  logic        clock;
  logic        reset;
  logic [31:0] btb_cur_pc;
  logic [31:0] btb_pred_pc;
  logic        btb_pred_valid;
  logic        ifetch_req_valid;
  logic        ifetch_req_ready;
  logic [31:0] ifetch_req_addr;
  logic        ifetch_rsp_valid;
  logic [31:0] ifetch_rsp_data;
  logic        ifetch_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_pred_taken;
  logic [31:0] out_pred_pc;
  logic        out_err;

  ysyx_24070003_ifu #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clock            (clock),
    .reset            (reset),
    .btb_cur_pc       (btb_cur_pc),
    .btb_pred_pc      (btb_pred_pc),
    .btb_pred_valid   (btb_pred_valid),
    .ifetch_req_valid (ifetch_req_valid),
    .ifetch_req_ready (ifetch_req_ready),
    .ifetch_req_addr  (ifetch_req_addr),
    .ifetch_rsp_valid (ifetch_rsp_valid),
    .ifetch_rsp_data  (ifetch_rsp_data),
    .ifetch_rsp_err   (ifetch_rsp_err),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_inst         (out_inst),
    .out_pred_taken   (out_pred_taken),
    .out_pred_pc      (out_pred_pc),
    .out_err          (out_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] pred_pc;
    logic        err;
  } ent_t;

  int n_pass;
  int n_total;

  // Stimulus configuration
  int          rdy_mode;   // 0: always ready, 1: random, 2: never
  int          ord_mode;   // same encoding for out_ready
  int          lat_min;
  int          lat_max;
  bit          rand_redir;
  bit          redir_req;
  logic [31:0] redir_tgt;
  logic [31:0] btb_src [4];
  logic [31:0] btb_dst [4];
  int          btb_n;
  logic [31:0] fault_addr [4];
  int          fault_n;

  // Reference state
  ent_t        expq [$];
  logic [31:0] exp_next;
  bit          os_valid;
  bit          os_stale;
  ent_t        os_ent;
  logic [31:0] os_addr;
  int          os_wait;
  bit          req_stale;
  bit          req_seen;
  logic [31:0] req_hold;
  logic [31:0] acc_log [$];
  ent_t        pop_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic btb_hit(input logic [31:0] a);
    for (int i = 0; i < btb_n; i++) if (btb_src[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] btb_tgt(input logic [31:0] a);
    for (int i = 0; i < btb_n; i++) if (btb_src[i] == a) return btb_dst[i];
    return 32'h0;
  endfunction

  function automatic logic is_fault(input logic [31:0] a);
    for (int i = 0; i < fault_n; i++) if (fault_addr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_clear();
    expq.delete();
    acc_log.delete();
    pop_log.delete();
    exp_next  = RST_PC;
    os_valid  = 0;
    os_stale  = 0;
    req_stale = 0;
    req_seen  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, ifetch_req_valid, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_pc"}, out_pc, 0);
    chk({tag, "_out_inst"}, out_inst, 0);
    chk({tag, "_out_pred_taken"}, out_pred_taken, 0);
    chk({tag, "_out_pred_pc"}, out_pred_pc, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_btb_cur_pc"}, btb_cur_pc, RST_PC);
  endtask

  task automatic do_reset(input bit check_vals, input string tag);
    @(negedge clock);
    reset            = 1'b0;
    ifetch_req_ready = 1'b0;
    ifetch_rsp_valid = 1'b0;
    ifetch_rsp_data  = 32'h0;
    ifetch_rsp_err   = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    out_ready        = 1'b0;
    #1;
    if (check_vals) check_reset_outputs(tag);
    model_clear();
    @(negedge clock);
    btb_pred_valid = btb_hit(btb_cur_pc);
    btb_pred_pc    = btb_tgt(btb_cur_pc);
    reset          = 1'b1;
  endtask

  // Judge the cycle about to be clocked, then advance the reference by its events.
  task automatic evaluate();
    int   pre_size;
    logic hit;
    pre_size = expq.size();

    chk("out_valid", out_valid, (expq.size() != 0));
    if (out_valid && expq.size() != 0) begin
      chk("out_pc", out_pc, expq[0].pc);
      chk("out_inst", out_inst, expq[0].inst);
      chk("out_pred_taken", out_pred_taken, expq[0].taken);
      chk("out_pred_pc", out_pred_pc, expq[0].pred_pc);
      chk("out_err", out_err, expq[0].err);
    end

    if (ifetch_req_valid) begin
      if (req_seen) chk("req_addr_hold", ifetch_req_addr, req_hold);
      if (os_valid) chk("second_outstanding", ifetch_req_valid, 0);
      req_seen = 1;
      req_hold = ifetch_req_addr;
    end else if (req_seen) begin
      chk("req_withdrawn", ifetch_req_valid, 1);
      req_seen = 0;
    end

    if (redirect_valid) begin
      expq.delete();
      if (ifetch_req_valid) req_stale = 1;
      exp_next = redirect_pc;
    end else if (out_valid && out_ready && expq.size() != 0) begin
      pop_log.push_back(expq.pop_front());
    end

    if (ifetch_rsp_valid) begin
      if (!redirect_valid && !os_stale) expq.push_back(os_ent);
      os_valid = 0;
    end else if (os_valid) begin
      if (redirect_valid) os_stale = 1;
      os_wait--;
    end

    if (ifetch_req_valid && ifetch_req_ready) begin
      chk("room_at_accept", (pre_size < QD), 1);
      if (req_stale) begin
        os_stale  = 1;
        req_stale = 0;
      end else begin
        chk("req_addr", ifetch_req_addr, exp_next);
        chk("btb_cur_pc", btb_cur_pc, exp_next);
        acc_log.push_back(ifetch_req_addr);
        hit            = btb_hit(exp_next);
        os_stale       = 0;
        os_ent.pc      = exp_next;
        os_ent.inst    = inst_of(exp_next);
        os_ent.taken   = hit;
        os_ent.pred_pc = hit ? btb_tgt(exp_next) : exp_next + 32'd4;
        os_ent.err     = is_fault(exp_next);
        exp_next       = os_ent.pred_pc;
      end
      os_valid = 1;
      os_addr  = ifetch_req_addr;
      os_wait  = $urandom_range(lat_max, lat_min);
      req_seen = 0;
    end
  endtask

  task automatic step();
    @(negedge clock);
    ifetch_req_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    out_ready        = (ord_mode == 0) ? 1'b1 : (ord_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    btb_pred_valid   = btb_hit(btb_cur_pc);
    btb_pred_pc      = btb_tgt(btb_cur_pc);
    if (os_valid && os_wait <= 0) begin
      ifetch_rsp_valid = 1'b1;
      ifetch_rsp_data  = inst_of(os_addr);
      ifetch_rsp_err   = is_fault(os_addr);
    end else begin
      ifetch_rsp_valid = 1'b0;
      ifetch_rsp_data  = $urandom;
      ifetch_rsp_err   = 1'b0;
    end
    if (rand_redir && $urandom_range(0, 24) == 0) begin
      redir_req = 1;
      redir_tgt = (($urandom_range(0, 1) == 0) ? 32'h3000_0000 : 32'h8000_0000)
                  + 32'($urandom_range(0, 7)) * 32'd4;
    end
    redirect_valid = redir_req;
    redirect_pc    = redir_req ? redir_tgt : $urandom;
    redir_req      = 0;
    #1;
    evaluate();
  endtask

  task automatic wait_acc(input int n, input string tag);
    for (int i = 0; i < 200 && acc_log.size() < n; i++) step();
    chk({tag, "_acc_count"}, (acc_log.size() >= n), 1);
  endtask

  task automatic wait_pop(input int n, input string tag);
    for (int i = 0; i < 300 && pop_log.size() < n; i++) step();
    chk({tag, "_pop_count"}, (pop_log.size() >= n), 1);
  endtask

  task automatic wait_outstanding(input string tag);
    for (int i = 0; i < 100 && !os_valid; i++) step();
    chk({tag, "_outstanding"}, os_valid, 1);
  endtask

  task automatic default_cfg();
    rdy_mode   = 0;
    ord_mode   = 0;
    lat_min    = 0;
    lat_max    = 0;
    rand_redir = 0;
    redir_req  = 0;
    redir_tgt  = 32'h0;
    btb_n      = 0;
    fault_n    = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   idle_cycles;
    int   acc0;
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    btb_pred_valid = 1'b0;
    btb_pred_pc    = 32'h0;
    default_cfg();

    // Reset values, then sequential fetch with BTB misses
    do_reset(1, "rst");
    wait_acc(3, "seq");
    if (acc_log.size() >= 3) begin
      chk("seq_addr0", acc_log[0], 32'h3000_0000);
      chk("seq_addr1", acc_log[1], 32'h3000_0004);
      chk("seq_addr2", acc_log[2], 32'h3000_0008);
    end
    wait_pop(3, "seq");
    if (pop_log.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("seq_pop_pc", pop_log[k].pc, 32'h3000_0000 + 32'(k) * 32'd4);
        chk("seq_pop_taken", pop_log[k].taken, 0);
      end
    end

    // BTB hit redirects the fetch stream
    default_cfg();
    btb_src[0] = 32'h3000_0004;
    btb_dst[0] = 32'h3000_0100;
    btb_n      = 1;
    do_reset(0, "");
    wait_acc(3, "btb");
    if (acc_log.size() >= 3) chk("btb_addr2", acc_log[2], 32'h3000_0100);
    wait_pop(2, "btb");
    if (pop_log.size() >= 2) begin
      chk("btb_pop_pc", pop_log[1].pc, 32'h3000_0004);
      chk("btb_pop_taken", pop_log[1].taken, 1);
      chk("btb_pop_pred", pop_log[1].pred_pc, 32'h3000_0100);
    end

    // Decoder stalled: exactly QD fetches, then silence; resume without loss
    default_cfg();
    ord_mode = 2;
    do_reset(0, "");
    for (int i = 0; i < 12; i++) step();
    chk("stall_fetches", acc_log.size(), 2);
    idle_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (!ifetch_req_valid) idle_cycles++;
    end
    chk("stall_req_idle", idle_cycles, 6);
    chk("stall_out_valid", out_valid, 1);
    ord_mode = 0;
    wait_pop(6, "resume");
    if (pop_log.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("resume_pc", pop_log[k].pc, 32'h3000_0000 + 32'(k) * 32'd4);
    end

    // Redirect while a response is outstanding
    default_cfg();
    lat_min = 2;
    lat_max = 2;
    do_reset(0, "");
    wait_outstanding("rw");
    acc0      = acc_log.size();
    redir_req = 1;
    redir_tgt = 32'h8000_0000;
    step();
    @(posedge clock);
    #1;
    chk("rw_out_valid_next", out_valid, 0);
    wait_acc(acc0 + 1, "rw");
    if (acc_log.size() > acc0) chk("rw_next_addr", acc_log[acc0], 32'h8000_0000);

    // Redirect while a request is held unaccepted
    default_cfg();
    rdy_mode = 2;
    do_reset(0, "");
    for (int i = 0; i < 20 && !ifetch_req_valid; i++) step();
    chk("rq_req_valid", ifetch_req_valid, 1);
    redir_req = 1;
    redir_tgt = 32'h8000_0000;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rq_addr_held", ifetch_req_addr, 32'h3000_0000);
    end
    rdy_mode = 0;
    wait_acc(1, "rq");
    if (acc_log.size() >= 1) chk("rq_first_fresh", acc_log[0], 32'h8000_0000);
    wait_pop(1, "rq");
    if (pop_log.size() >= 1) chk("rq_first_pop", pop_log[0].pc, 32'h8000_0000);

    // Access fault entry flows through, fetch continues
    default_cfg();
    fault_addr[0] = 32'h3000_0008;
    fault_n       = 1;
    do_reset(0, "");
    wait_pop(4, "flt");
    if (pop_log.size() >= 4) begin
      chk("flt_pc", pop_log[2].pc, 32'h3000_0008);
      chk("flt_err", pop_log[2].err, 1);
      chk("flt_next_pc", pop_log[3].pc, 32'h3000_000C);
      chk("flt_next_err", pop_log[3].err, 0);
    end

    // Reset asserted mid-WAIT with a non-empty queue
    default_cfg();
    ord_mode = 2;
    lat_min  = 3;
    lat_max  = 3;
    do_reset(0, "");
    for (int i = 0; i < 40 && !(os_valid && expq.size() > 0); i++) step();
    chk("mw_setup", (os_valid && out_valid), 1);
    do_reset(1, "midwait_rst");

    // Random traffic against the reference
    default_cfg();
    rdy_mode   = 1;
    ord_mode   = 1;
    lat_min    = 0;
    lat_max    = 2;
    rand_redir = 1;
    btb_src[0] = 32'h3000_000C; btb_dst[0] = 32'h3000_0040;
    btb_src[1] = 32'h3000_0048; btb_dst[1] = 32'h3000_0000;
    btb_src[2] = 32'h8000_0010; btb_dst[2] = 32'h8000_0100;
    btb_src[3] = 32'h8000_0104; btb_dst[3] = 32'h8000_0004;
    btb_n      = 4;
    fault_addr[0] = 32'h3000_0010;
    fault_addr[1] = 32'h8000_0008;
    fault_n       = 2;
    do_reset(0, "");
    for (int i = 0; i < 3000; i++) step();
    chk("rand_progress", (pop_log.size() > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
